// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit running one handshaked data-memory access at a time,
// with lane alignment, load extension and misalign/timeout fault reporting.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op,
    input  logic [31:0] daddr,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        we,
    output logic [4:0]  wrd,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;
    state_t      r_state, w_next;
    logic [5:0]  r_op;
    logic [31:0] r_addr, r_sdata, r_wdata;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;
    logic        r_misalign, r_timeout;
    logic        w_valid_op, w_mis, w_load, w_accept;
    logic [16:0] w_cnt_inc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_valid_op = op >= 6'd19 && op <= 6'd26;
    assign w_mis      = ((op == 6'd20 || op == 6'd23 || op == 6'd25) && daddr[0]) ||
                        ((op == 6'd21 || op == 6'd26) && daddr[1:0] != 2'b00);
    assign w_accept   = r_state == IDLE && in_valid && w_valid_op;
    assign w_load     = r_op >= 6'd19 && r_op <= 6'd23;
    assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
    assign w_byte     = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_ext      = r_op == 6'd19 ? {{24{w_byte[7]}}, w_byte} :
                        r_op == 6'd20 ? {{16{w_half[15]}}, w_half} :
                        r_op == 6'd22 ? {24'd0, w_byte} :
                        r_op == 6'd23 ? {16'd0, w_half} : mem_rdata;

    assign in_ready  = r_state == IDLE;
    assign mem_req   = r_state == ACCESS;
    assign mem_we    = r_op >= 6'd24 && r_op <= 6'd26;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_be    = r_op == 6'd24 ? 4'b0001 << r_addr[1:0] :
                       r_op == 6'd25 ? (r_addr[1] ? 4'b1100 : 4'b0011) :
                       (w_load || r_op == 6'd26) ? 4'b1111 : 4'b0000;
    assign mem_wdata = r_op == 6'd24 ? {4{r_sdata[7:0]}} :
                       r_op == 6'd25 ? {2{r_sdata[15:0]}} :
                       r_op == 6'd26 ? r_sdata : 32'd0;
    assign done      = r_state == RESP || r_state == FAULT;
    assign we        = r_state == RESP && w_load;
    assign wrd       = r_rd;
    assign wdata     = r_wdata;
    assign misalign  = r_state == FAULT && r_misalign;
    assign timeout   = r_state == FAULT && r_timeout;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_mis ? FAULT : ACCESS) : IDLE;
            ACCESS:  w_next = mem_ack ? RESP : (w_cnt_inc == 17'(TIMEOUT_CYCLES) ? FAULT : ACCESS);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= op;
                r_addr     <= daddr;
                r_sdata    <= sdata;
                r_rd       <= rd;
                r_cnt      <= '0;
                r_misalign <= w_mis;
                r_timeout  <= 1'b0;
            end
            if (r_state == ACCESS) begin
                r_cnt <= w_cnt_inc[15:0];
                if (mem_ack && w_load) r_wdata <= w_ext;
                if (!mem_ack && w_next == FAULT) r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized accesses checked against a byte-lane reference model.
module tb_lsu_mem_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] daddr = '0, sdata = '0, mem_rdata = '0;
    logic [4:0]  rd = '0;
    logic        in_ready, mem_req, mem_we, done, we, misalign, timeout;
    logic [31:0] mem_addr, mem_wdata, wdata;
    logic [3:0]  mem_be;
    logic [4:0]  wrd;
    int          errors = 0, checks = 0;
    logic [31:0] last_wdata = '0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .daddr(daddr), .sdata(sdata), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .done(done), .we(we), .wrd(wrd), .wdata(wdata),
        .misalign(misalign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sz(input logic [5:0] o);
        return (o == 19 || o == 22 || o == 24) ? 1 : (o == 20 || o == 23 || o == 25) ? 2 : 4;
    endfunction

    function automatic bit is_load(input logic [5:0] o);
        return o <= 23;
    endfunction

    task automatic access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] s,
                          input logic [31:0] r, input logic [4:0] d, input int lat);
        int n, off, base;
        bit mis;
        logic [3:0] ebe;
        logic [31:0] ewd, eld, t, mask;
        n = sz(o);
        off = int'(a[1:0]);
        base = off - off % n;
        mis = (off % n) != 0;
        ebe = '0;
        ewd = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= base && b < base + n) ebe[b] = 1'b1;
            if (!is_load(o)) ewd[8*b +: 8] = s[8*(b % n) +: 8];
        end
        if (is_load(o)) ebe = 4'hF;
        t = r >> (8 * base);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        eld = t & mask;
        if ((o == 19 || o == 20) && eld[8*n-1]) eld = eld | ~mask;
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1; op = o; daddr = a; sdata = s; rd = d;
        step();
        in_valid = 1'b0; op = 6'($urandom); daddr = $urandom; sdata = $urandom; rd = 5'($urandom);
        if (mis) begin
            chk("mis_done", 32'(done), 1);
            chk("mis_flag", 32'(misalign), 1);
            chk("mis_timeout", 32'(timeout), 0);
            chk("mis_we", 32'(we), 0);
            chk("mis_req", 32'(mem_req), 0);
            step();
            chk("mis_done_clr", 32'(done), 0);
            chk("mis_ready", 32'(in_ready), 1);
            return;
        end
        chk("req", 32'(mem_req), 1);
        chk("addr", mem_addr, {a[31:2], 2'b00});
        chk("be", 32'(ebe), 32'(mem_be));
        chk("mem_we", 32'(mem_we), 32'(!is_load(o)));
        chk("mem_wdata", mem_wdata, ewd);
        chk("busy", 32'(in_ready), 0);
        repeat (lat) begin
            step();
            chk("req_hold", 32'(mem_req), 1);
            chk("be_hold", 32'(mem_be), 32'(ebe));
            chk("no_done_wait", 32'(done), 0);
        end
        mem_ack = 1'b1; mem_rdata = r;
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk("done", 32'(done), 1);
        chk("req_drop", 32'(mem_req), 0);
        chk("ok_misalign", 32'(misalign), 0);
        chk("ok_timeout", 32'(timeout), 0);
        chk("wrd", 32'(wrd), 32'(d));
        chk("we", 32'(we), 32'(is_load(o)));
        if (is_load(o)) begin
            chk("load_data", wdata, eld);
            last_wdata = eld;
        end
        step();
        chk("done_pulse", 32'(done), 0);
        chk("we_clr", 32'(we), 0);
        chk("ready_after", 32'(in_ready), 1);
        chk("wdata_hold", wdata, last_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_flags", 32'({misalign, timeout}), 0);
        rst_n = 1'b1;
        step();
        access(21, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 0);
        chk("lw_val", wdata, 32'hDEADBEEF);
        access(19, 32'h103, 32'h0, 32'h80FF0000, 5'd6, 1);
        chk("lb_val", wdata, 32'hFFFFFF80);
        access(22, 32'h103, 32'h0, 32'h80FF0000, 5'd7, 0);
        chk("lbu_val", wdata, 32'h00000080);
        access(23, 32'h102, 32'h0, 32'h80FF0000, 5'd8, 2);
        chk("lhu_val", wdata, 32'h000080FF);
        access(24, 32'h21, 32'h12345678, 32'h0, 5'd9, 0);
        chk("sb_keeps_wdata", wdata, 32'h000080FF);
        access(25, 32'h41, 32'h12345678, 32'h0, 5'd10, 0);
        access(21, 32'h8, 32'h0, 32'hCAFEF00D, 5'd0, 2);
        foreach (op[i]) begin end
        in_valid = 1'b1; op = 6'd5; daddr = 32'h100;
        step();
        chk("badop_ready", 32'(in_ready), 1);
        chk("badop_req", 32'(mem_req), 0);
        op = 6'd27;
        step();
        in_valid = 1'b0;
        chk("badop27_ready", 32'(in_ready), 1);
        chk("badop_done", 32'(done), 0);
        in_valid = 1'b1; op = 6'd21; daddr = 32'h200; rd = 5'd3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_req", 32'(mem_req), 1);
            chk("to_wait_done", 32'(done), 0);
            step();
        end
        chk("to_done", 32'(done), 1);
        chk("to_flag", 32'(timeout), 1);
        chk("to_misalign", 32'(misalign), 0);
        chk("to_we", 32'(we), 0);
        chk("to_req_drop", 32'(mem_req), 0);
        mem_ack = 1'b1;
        step();
        chk("late_ack_done", 32'(done), 0);
        chk("late_ack_ready", 32'(in_ready), 1);
        step();
        chk("late_ack_req", 32'(mem_req), 0);
        mem_ack = 1'b0;
        in_valid = 1'b1; op = 6'd21; daddr = 32'h300;
        step();
        in_valid = 1'b0;
        chk("rst_mid_req", 32'(mem_req), 1);
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_req_drop", 32'(mem_req), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_ready", 32'(in_ready), 1);
        chk("rst_mid_wdata", wdata, 0);
        last_wdata = '0;
        rst_n = 1'b1;
        step();
        chk("rst_mid_no_done", 32'(done), 0);
        access(21, 32'h304, 32'h0, 32'h0BADC0DE, 5'd12, 1);
        for (int k = 0; k < 40; k++)
            access(6'(19 + $urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 2));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
